dsp_multich_ber: RTL

Parametrised multi-channel PRBS9 link tester, the successor of the single I/Q test top. It generates N_CH independent PRBS9 symbol streams at 1 symbol per N_PHASES clocks. It samples N_CH oversampled receive streams at a selectable phase, then runs one delay-search/lock FSM per channel. Each locked channel accumulates saturating BER sample and error counters. It sits between the transmit shaping path and the board-level LEDs and debug cores.

---
 rtl/dsp_multich_ber.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dsp_multich_ber.sv
// dsp_multich_ber
// Multi-channel PRBS9 link tester. Generates N_CH independent PRBS9 symbol
// streams (one symbol per N_PHASES clocks), samples N_CH oversampled receive
// streams at a selectable phase, searches each channel for the best delay
// against a local PRBS9 reference, then locks and accumulates saturating
// sample/error counters.
//
// Optional feature: define DSP_ERR_INJECT_EN to add i_err_inject, whose rising
// edge inverts o_tx_data[0] for exactly the next transmitted symbol.
//
// Ports:
//   clk           clock
//   i_rstn        synchronous active-low reset
//   i_en_tx       transmit PRBS advance enable
//   i_en_rx       receive / BER enable
//   i_phase_sel   receive sampling phase (values >= N_PHASES never fire)
//   i_rx_data     oversampled received bit per channel
//   i_err_inject  (DSP_ERR_INJECT_EN only) error-inject request, edge sensitive
//   o_tx_data     transmitted PRBS bit per channel
//   o_valid       symbol strobe (phase count == 0)
//   o_lock        per-channel lock flag
//   o_ber_zero    all channels locked with zero errors
//   o_ber_samp    per-channel compared-symbol counters (packed, ch0 in LSBs)
//   o_ber_error   per-channel error counters (packed, ch0 in LSBs)
module dsp_multich_ber #(
    parameter int                N_CH       = 2,
    parameter logic [9*N_CH-1:0] SEEDS      = {N_CH{9'h1AA}},
    parameter int                N_PHASES   = 4,
    parameter int                NB_PHASE   = 2,
    parameter int                N_SAMPLES  = 511,
    parameter int                N_POS      = 511,
    parameter int                NB_BER_CNT = 64
) (
    input  logic                         clk,
    input  logic                         i_rstn,
    input  logic                         i_en_tx,
    input  logic                         i_en_rx,
    input  logic [NB_PHASE-1:0]          i_phase_sel,
    input  logic [N_CH-1:0]              i_rx_data,
`ifdef DSP_ERR_INJECT_EN
    input  logic                         i_err_inject,
`endif
    output logic [N_CH-1:0]              o_tx_data,
    output logic                         o_valid,
    output logic [N_CH-1:0]              o_lock,
    output logic                         o_ber_zero,
    output logic [N_CH*NB_BER_CNT-1:0]   o_ber_samp,
    output logic [N_CH*NB_BER_CNT-1:0]   o_ber_error
);

    // Sample index and per-position error count widths; the error count is
    // one value wider than needed so its all-ones reset exceeds any real count.
    localparam int NB_SIDX = $clog2(N_SAMPLES + 1);
    localparam int NB_SCNT = $clog2(N_SAMPLES + 2);

    typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_LOCK} state_t;

    // ---------------- phase counter ----------------
    logic [NB_PHASE-1:0] ph_q, ph_d;
    logic                sym_stb, rx_stb;

    always_comb begin
        ph_d = (ph_q == NB_PHASE'(N_PHASES - 1)) ? '0 : ph_q + NB_PHASE'(1);
    end

    always_ff @(posedge clk) begin
        if (!i_rstn) ph_q <= '0;
        else         ph_q <= ph_d;
    end

    assign sym_stb = (ph_q == '0);
    assign rx_stb  = (ph_q == i_phase_sel);
    assign o_valid = sym_stb;

    // ---------------- error injection on channel 0 ----------------
    logic [N_CH-1:0] tx_inv;
`ifdef DSP_ERR_INJECT_EN
    logic inj_q, arm_q, arm_d, inv_q, inv_d;

    // A rising edge arms the inverter; the inversion window opens at the next
    // symbol boundary and closes at the one after.
    always_comb begin
        arm_d = arm_q | (i_err_inject & ~inj_q);
        inv_d = inv_q;
        if (sym_stb) begin
            inv_d = arm_d;
            arm_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rstn) begin
            inj_q <= 1'b0;
            arm_q <= 1'b0;
            inv_q <= 1'b0;
        end else begin
            inj_q <= i_err_inject;
            arm_q <= arm_d;
            inv_q <= inv_d;
        end
    end

    assign tx_inv = N_CH'(inv_q);
`else
    assign tx_inv = '0;
`endif

    // ---------------- per-channel datapath and FSM ----------------
    logic [N_CH-1:0] err_zero;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        state_t                state_q, state_d;
        logic [8:0]            tx_q, tx_d, ref_q, ref_d;
        logic [510:0]          dl_q, dl_d;
        logic [8:0]            pos_q, pos_d, argmin_q, argmin_d;
        logic [NB_SIDX-1:0]    sidx_q, sidx_d;
        logic [NB_SCNT-1:0]    perr_q, perr_d, min_q, min_d, perr_fin;
        logic [NB_BER_CNT-1:0] samp_q, samp_d, err_q, err_d;
        logic                  mism, last_samp, last_pos, better, lock;

        assign mism      = i_rx_data[gi] ^ dl_q[pos_q];
        assign perr_fin  = perr_q + NB_SCNT'(mism);
        assign last_samp = (sidx_q == NB_SIDX'(N_SAMPLES - 1));
        assign last_pos  = (pos_q == 9'(N_POS - 1));
        assign better    = (perr_fin < min_q);   // strict: ties keep earlier pos

        // state register
        always_ff @(posedge clk) begin
            if (!i_rstn) state_q <= ST_IDLE;
            else         state_q <= state_d;
        end

        // next-state logic
        always_comb begin
            state_d = state_q;
            if (!i_en_rx) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE:   state_d = ST_SEARCH;
                    ST_SEARCH: if (rx_stb && last_samp && last_pos) state_d = ST_LOCK;
                    ST_LOCK:   state_d = ST_LOCK;
                    default:   state_d = ST_IDLE;
                endcase
            end
        end

        // output logic
        always_comb begin
            lock = (state_q == ST_LOCK);
        end

        // datapath next-state
        always_comb begin
            tx_d     = tx_q;
            ref_d    = ref_q;
            dl_d     = dl_q;
            pos_d    = pos_q;
            argmin_d = argmin_q;
            sidx_d   = sidx_q;
            perr_d   = perr_q;
            min_d    = min_q;
            samp_d   = samp_q;
            err_d    = err_q;

            if (sym_stb && i_en_tx) tx_d = {tx_q[7:0], tx_q[8] ^ tx_q[4]};

            // Reference runs whenever receive is enabled, independent of state,
            // so the delay line keeps a full history of recent reference bits.
            if (rx_stb && i_en_rx) begin
                ref_d = {ref_q[7:0], ref_q[8] ^ ref_q[4]};
                dl_d  = {dl_q[509:0], ref_q[8]};
            end

            case (state_q)
                ST_IDLE: begin
                    pos_d = '0;
                    if (i_en_rx) begin
                        sidx_d   = '0;
                        perr_d   = '0;
                        min_d    = '1;
                        argmin_d = '0;
                        samp_d   = '0;
                        err_d    = '0;
                    end
                end
                ST_SEARCH: begin
                    if (i_en_rx && rx_stb) begin
                        if (last_samp) begin
                            sidx_d = '0;
                            perr_d = '0;
                            if (better) begin
                                min_d    = perr_fin;
                                argmin_d = pos_q;
                            end
                            if (last_pos) begin
                                pos_d  = better ? pos_q : argmin_q;
                                samp_d = '0;
                                err_d  = '0;
                            end else begin
                                pos_d = pos_q + 9'd1;
                            end
                        end else begin
                            sidx_d = sidx_q + NB_SIDX'(1);
                            perr_d = perr_fin;
                        end
                    end
                end
                ST_LOCK: begin
                    if (i_en_rx && rx_stb) begin
                        if (!(&samp_q))        samp_d = samp_q + NB_BER_CNT'(1);
                        if (mism && !(&err_q)) err_d  = err_q + NB_BER_CNT'(1);
                    end
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!i_rstn) begin
                tx_q     <= SEEDS[9*gi +: 9];
                ref_q    <= SEEDS[9*gi +: 9];
                dl_q     <= '0;
                pos_q    <= '0;
                argmin_q <= '0;
                sidx_q   <= '0;
                perr_q   <= '0;
                min_q    <= '1;
                samp_q   <= '0;
                err_q    <= '0;
            end else begin
                tx_q     <= tx_d;
                ref_q    <= ref_d;
                dl_q     <= dl_d;
                pos_q    <= pos_d;
                argmin_q <= argmin_d;
                sidx_q   <= sidx_d;
                perr_q   <= perr_d;
                min_q    <= min_d;
                samp_q   <= samp_d;
                err_q    <= err_d;
            end
        end

        assign o_tx_data[gi]                            = tx_q[8] ^ tx_inv[gi];
        assign o_lock[gi]                               = lock;
        assign o_ber_samp[gi*NB_BER_CNT +: NB_BER_CNT]  = samp_q;
        assign o_ber_error[gi*NB_BER_CNT +: NB_BER_CNT] = err_q;
        assign err_zero[gi]                             = (err_q == '0);
    end

    assign o_ber_zero = (&o_lock) & (&err_zero);

endmodule
